fetch_controller: RTL and testbench

Sequences the 64-word, 32-bit synchronous instruction memory. It owns the program counter and drives the memory address. It absorbs the memory's one-cycle read latency with a 2-entry skid FIFO and presents fetched instructions to decode over a valid/ready handshake. It also handles branch/jump redirects and a halt request; it sits between the instruction memory and the decode stage.

---
 rtl/fetch_controller_if.sv | 43 ++++
 rtl/fetch_controller.sv | 136 +++++++++++++
 tb/tb_fetch_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Bundle between the fetch controller, the instruction memory and the decode
// stage. The controller takes the master side; memory/decode (or a bench)
// take the slave side.
interface fetch_controller_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_instruction;
  logic [31:0]           if_instruction;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_valid;
  logic                  if_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halt;
  logic                  halted;

  modport master (
    output imem_address,
    input  imem_instruction,
    output if_instruction,
    output if_pc,
    output if_valid,
    input  if_ready,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output halted
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    input  if_instruction,
    input  if_pc,
    input  if_valid,
    output if_ready,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  halted
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the program counter, hides the one-cycle
// memory read latency behind a 2-entry skid FIFO and hands instructions to
// decode over valid/ready. Supports redirects (flush + restart) and halt.
module fetch_controller #(
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic              clock,
  input  logic              reset,
  fetch_controller_if.master bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [31:0]           head_instr_q, head_instr_d;
  logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
  logic [31:0]           tail_instr_q, tail_instr_d;
  logic [ADDR_WIDTH-1:0] tail_pc_q, tail_pc_d;

  logic                  deq;
  logic                  push;
  logic                  issue;
  logic [2:0]            occupancy;

  // Next-state logic: FSM, issue decision, FIFO push/pop and redirect flush.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    inflight_d   = 1'b0;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;

    deq  = (count_q != 2'd0) && bus.if_ready;
    push = inflight_q && !bus.redirect_valid;
    // Entries that will be held once this cycle's pop and pending push settle;
    // a new read may only start if its data is guaranteed a free slot.
    occupancy = {1'b0, count_q} - {2'b00, deq} + {2'b00, inflight_q};
    issue = (state_q == RUN) && !bus.halt && !bus.redirect_valid &&
            (occupancy < 3'd2);

    case (state_q)
      RUN:     if (bus.halt)  state_d = HALT;
      HALT:    if (!bus.halt) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (bus.redirect_valid) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      fetch_pc_d = bus.redirect_pc;
    end else begin
      inflight_d = issue;
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      end

      case ({push, deq})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_instr_d = bus.imem_instruction;
            head_pc_d    = req_pc_q;
          end else begin
            tail_instr_d = bus.imem_instruction;
            tail_pc_d    = req_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_instr_d = tail_instr_q;
          head_pc_d    = tail_pc_q;
          count_d      = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_instr_d = bus.imem_instruction;
            head_pc_d    = req_pc_q;
          end else begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            tail_instr_d = bus.imem_instruction;
            tail_pc_d    = req_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

  // Outputs come straight from registers; head fields are masked when empty.
  always_comb begin
    bus.imem_address   = fetch_pc_q;
    bus.if_valid       = (count_q != 2'd0);
    bus.if_instruction = bus.if_valid ? head_instr_q : 32'h0;
    bus.if_pc          = bus.if_valid ? head_pc_q : '0;
    bus.halted         = (state_q == HALT) && !inflight_q;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a per-cycle vector table covering
// reset, streaming, backpressure, redirect, halt and mid-stream reset, then
// hand-written sequences for address wrap and a redirect while the FIFO is full.
module tb_fetch_controller;

  localparam int AW = 6;

  logic clock;
  logic reset;

  fetch_controller_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_controller #(
    .ADDR_WIDTH(AW),
    .RESET_PC  (6'd0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous memory model: word k holds 0x1000_0000 + k, one-cycle latency.
  always @(posedge clock) begin
    bus.imem_instruction <= 32'h1000_0000 + {26'b0, bus.imem_address};
  end

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic          rst;
    logic          rdy;
    logic          hlt;
    logic          rv;
    logic [AW-1:0] rpc;
    logic          ev;
    logic [AW-1:0] epc;
    logic [AW-1:0] eaddr;
    logic          eh;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   step       = 0;

  function automatic void add(logic rst, logic rdy, logic hlt, logic rv,
                              logic [AW-1:0] rpc, logic ev, logic [AW-1:0] epc,
                              logic [AW-1:0] eaddr, logic eh);
    vecs.push_back({rst, rdy, hlt, rv, rpc, ev, epc, eaddr, eh});
  endfunction

  task automatic compare(input string what, input logic [31:0] actual,
                         input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at step %0d: got 0x%08h, expected 0x%08h",
               what, step, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic hlt,
                               input logic rv, input logic [AW-1:0] rpc);
    reset              = rst;
    bus.if_ready       = rdy;
    bus.halt           = hlt;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic checkOutput(input logic ev, input logic [AW-1:0] epc,
                             input logic [AW-1:0] eaddr, input logic eh);
    logic [31:0] exp_instr;
    exp_instr = ev ? (32'h1000_0000 + {26'b0, epc}) : 32'h0;
    compare("if_valid",       {31'b0, bus.if_valid},   {31'b0, ev});
    compare("if_pc",          {26'b0, bus.if_pc},      ev ? {26'b0, epc} : 32'h0);
    compare("if_instruction", bus.if_instruction,      exp_instr);
    compare("imem_address",   {26'b0, bus.imem_address}, {26'b0, eaddr});
    compare("halted",         {31'b0, bus.halted},     {31'b0, eh});
  endtask

  // One cycle: outputs depend only on registers, so drive and sample at negedge.
  task automatic runCycle(input logic rst, input logic rdy, input logic hlt,
                          input logic rv, input logic [AW-1:0] rpc,
                          input logic ev, input logic [AW-1:0] epc,
                          input logic [AW-1:0] eaddr, input logic eh);
    @(negedge clock);
    applyStimulus(rst, rdy, hlt, rv, rpc);
    checkOutput(ev, epc, eaddr, eh);
    step++;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);

    //   rst rdy hlt rv  rpc    ev  epc    addr   halted
    add(1, 1, 0, 0, 6'd0,  0, 6'd0,  6'd0,  0);   // reset
    add(1, 1, 0, 0, 6'd0,  0, 6'd0,  6'd0,  0);
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd0,  0);   // cycle 0: issue pc 0
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd1,  0);   // cycle 1: push
    add(0, 1, 0, 0, 6'd0,  1, 6'd0,  6'd2,  0);   // cycle 2: first valid
    add(0, 1, 0, 0, 6'd0,  1, 6'd1,  6'd3,  0);
    add(0, 0, 0, 0, 6'd0,  1, 6'd2,  6'd4,  0);   // backpressure 5 cycles
    add(0, 0, 0, 0, 6'd0,  1, 6'd2,  6'd4,  0);
    add(0, 0, 0, 0, 6'd0,  1, 6'd2,  6'd4,  0);
    add(0, 0, 0, 0, 6'd0,  1, 6'd2,  6'd4,  0);
    add(0, 0, 0, 0, 6'd0,  1, 6'd2,  6'd4,  0);
    add(0, 1, 0, 0, 6'd0,  1, 6'd2,  6'd4,  0);   // release: deq + issue
    add(0, 1, 0, 0, 6'd0,  1, 6'd3,  6'd5,  0);
    add(0, 1, 0, 1, 6'd40, 1, 6'd4,  6'd6,  0);   // redirect, deq pc 4
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd40, 0);
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd41, 0);
    add(0, 1, 0, 0, 6'd0,  1, 6'd40, 6'd42, 0);
    add(0, 1, 0, 0, 6'd0,  1, 6'd41, 6'd43, 0);
    add(0, 1, 1, 0, 6'd0,  1, 6'd42, 6'd44, 0);   // halt for 6 cycles
    add(0, 1, 1, 0, 6'd0,  1, 6'd43, 6'd44, 1);
    add(0, 1, 1, 0, 6'd0,  0, 6'd0,  6'd44, 1);
    add(0, 1, 1, 0, 6'd0,  0, 6'd0,  6'd44, 1);
    add(0, 1, 1, 0, 6'd0,  0, 6'd0,  6'd44, 1);
    add(0, 1, 1, 0, 6'd0,  0, 6'd0,  6'd44, 1);
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd44, 1);   // halt falls
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd44, 0);   // resume issue at 44
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd45, 0);
    add(0, 1, 0, 0, 6'd0,  1, 6'd44, 6'd46, 0);
    add(0, 1, 1, 0, 6'd0,  1, 6'd45, 6'd47, 0);   // halt again
    add(0, 1, 1, 1, 6'd10, 1, 6'd46, 6'd47, 1);   // redirect while halted
    add(0, 1, 1, 0, 6'd0,  0, 6'd0,  6'd10, 1);
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd10, 1);
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd10, 0);
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd11, 0);
    add(0, 1, 0, 0, 6'd0,  1, 6'd10, 6'd12, 0);
    add(0, 1, 0, 0, 6'd0,  1, 6'd11, 6'd13, 0);
    add(0, 0, 0, 0, 6'd0,  1, 6'd12, 6'd14, 0);   // fill to count 2
    add(0, 0, 0, 0, 6'd0,  1, 6'd12, 6'd14, 0);
    add(1, 1, 0, 0, 6'd0,  1, 6'd12, 6'd14, 0);   // reset pulse
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd0,  0);
    add(0, 1, 0, 0, 6'd0,  0, 6'd0,  6'd1,  0);
    add(0, 1, 0, 0, 6'd0,  1, 6'd0,  6'd2,  0);
    add(0, 1, 0, 0, 6'd0,  1, 6'd1,  6'd3,  0);

    foreach (vecs[i]) begin
      runCycle(vecs[i].rst, vecs[i].rdy, vecs[i].hlt, vecs[i].rv, vecs[i].rpc,
               vecs[i].ev, vecs[i].epc, vecs[i].eaddr, vecs[i].eh);
    end

    // Long stream across the 63 -> 0 address wrap.
    for (int k = 0; k < 70; k++) begin
      runCycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,
               1'b1, AW'(2 + k), AW'(4 + k), 1'b0);
    end

    // Fill the FIFO, then redirect to 20 with a deq in the same cycle.
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd8,  6'd10, 1'b0);
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd8,  6'd10, 1'b0);
    runCycle(1'b0, 1'b1, 1'b0, 1'b1, 6'd20, 1'b1, 6'd8,  6'd10, 1'b0);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd20, 1'b0);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd21, 1'b0);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd20, 6'd22, 1'b0);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd21, 6'd23, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
